matvec_mac_engine: RTL and testbench

//  Parametrised ROWS x COLS matrix-vector MAC engine: loads vector B and matrix A from one

---
 rtl/matvec_pkg.sv | 26 ++
 rtl/mac_lane.sv | 77 +++++++
 rtl/matvec_mac_engine.sv | 173 +++++++++++++++++
 tb/tb_matvec_mac_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and result-limit helpers for the matrix-vector MAC engine.
package matvec_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL_B  = 3'd1,
        FILL_A  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int LIM_W = 64;

    // Largest representable result; callers truncate to ACC_W.
    function automatic logic [LIM_W-1:0] res_max(int acc_w, logic is_signed);
        if (is_signed)
            return (LIM_W'(1) << (acc_w - 1)) - LIM_W'(1);
        return (acc_w >= LIM_W) ? '1 : (LIM_W'(1) << acc_w) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] res_min(int acc_w, logic is_signed);
        return is_signed ? (LIM_W'(1) << (acc_w - 1)) : '0;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered product, then accumulate with saturate or wrap.
module mac_lane
    import matvec_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_start,
    input  logic             acc_clr,
    input  logic             mul_en,
    input  logic             signed_mode,
    input  logic             sat_en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);
    // One guard bit is enough: |product| never exceeds the accumulator range.
    localparam int EW = ACC_W + 1;

    logic [EW-1:0]         prod_q, prod_d;
    logic                  prod_vld_q, prod_vld_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic signed [2*DW-1:0] prod_s;
    logic [2*DW-1:0]       prod_u;
    logic [EW-1:0]         acc_ext, sum;
    logic                  sum_ovf;

    always_comb begin
        prod_s     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        prod_u     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        prod_d     = signed_mode ? {{(EW-2*DW){prod_s[2*DW-1]}}, prod_s}
                                 : {{(EW-2*DW){1'b0}}, prod_u};
        prod_vld_d = mul_en;
        acc_ext    = signed_mode ? {acc_q[ACC_W-1], acc_q} : {1'b0, acc_q};
        sum        = acc_ext + prod_q;
        sum_ovf    = signed_mode ? (sum[EW-1] != sum[EW-2]) : sum[EW-1];

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (job_start)
            ovf_d = 1'b0;
        else if (prod_vld_q && sum_ovf)
            ovf_d = 1'b1;

        if (acc_clr) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            if (sum_ovf && sat_en)
                acc_d = (signed_mode && sum[EW-1]) ? ACC_W'(res_min(ACC_W, 1'b1))
                                                   : ACC_W'(res_max(ACC_W, signed_mode));
            else
                acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/matvec_mac_engine.sv
// ROWS x COLS matrix-vector MAC engine: stream-load B and A, run ROWS lanes, drain results.
module matvec_mac_engine
    import matvec_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    acc_clear,
    input  logic                    signed_mode,
    input  logic                    sat_en,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic [$clog2(ROWS)-1:0] res_idx,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           tail_q, tail_d;
    logic           signed_q, signed_d;
    logic           sat_q, sat_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           res_valid_q, res_valid_d;
    logic [RW-1:0]  res_idx_q, res_idx_d;
    logic           beat, job_start, acc_clr, mul_en, last_col, last_row;

    // FIFO storage: written in stream order, popped in lock-step during COMPUTE.
    logic [DW-1:0]    b_mem [COLS];
    logic [DW-1:0]    a_mem [ROWS][COLS];
    logic [ACC_W-1:0] lane_acc [ROWS];
    logic [ROWS-1:0]  lane_ovf;

    assign beat     = in_valid & in_ready_q;
    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        tail_d    = tail_q;
        signed_d  = signed_q;
        sat_d     = sat_q;
        res_idx_d = res_idx_q;
        job_start = 1'b0;
        acc_clr   = 1'b0;
        mul_en    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d   = FILL_B;
                job_start = 1'b1;
                acc_clr   = acc_clear;
                signed_d  = signed_mode;
                sat_d     = sat_en;
                col_d     = '0;
                row_d     = '0;
                tail_d    = 1'b0;
            end
            FILL_B: if (beat) begin
                col_d = last_col ? '0 : col_q + CW'(1);
                if (last_col) state_d = FILL_A;
            end
            FILL_A: if (beat) begin
                col_d = last_col ? '0 : col_q + CW'(1);
                if (last_col) begin
                    row_d = last_row ? '0 : row_q + RW'(1);
                    if (last_row) state_d = COMPUTE;
                end
            end
            // COLS pop cycles plus one tail cycle to accumulate the last product.
            COMPUTE: if (tail_q) begin
                tail_d    = 1'b0;
                state_d   = DRAIN;
                res_idx_d = '0;
            end else begin
                mul_en = 1'b1;
                col_d  = last_col ? '0 : col_q + CW'(1);
                tail_d = last_col;
            end
            DRAIN: if (res_valid_q && res_ready) begin
                if (res_idx_q == RW'(ROWS - 1)) begin
                    state_d   = DONE;
                    res_idx_d = '0;
                end else begin
                    res_idx_d = res_idx_q + RW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == FILL_B) || (state_d == FILL_A);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        res_valid_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            tail_q      <= 1'b0;
            signed_q    <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tail_q      <= tail_d;
            signed_q    <= signed_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat && state_q == FILL_B)
            b_mem[col_q] <= in_data;
        else if (beat && state_q == FILL_A)
            a_mem[row_q][col_q] <= in_data;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .job_start   (job_start),
            .acc_clr     (acc_clr),
            .mul_en      (mul_en),
            .signed_mode (signed_q),
            .sat_en      (sat_q),
            .a           (a_mem[r][col_q]),
            .b           (b_mem[col_q]),
            .acc         (lane_acc[r]),
            .ovf         (lane_ovf[r])
        );
    end

    // Accumulators are frozen during DRAIN, so a direct mux stays stable under stalls.
    assign res_data  = res_valid_q ? lane_acc[res_idx_q] : '0;
    assign res_idx   = res_idx_q;
    assign res_valid = res_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = |lane_ovf;

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Bench for matvec_mac_engine: 24-bit and 16-bit instances on shared stimulus, model-driven scoreboard.
module tb_matvec_mac_engine;
    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, acc_clear = 1'b0, signed_mode = 1'b0, sat_en = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0, res_ready = 1'b0;

    logic        in_ready, res_valid, busy, done, overflow;
    logic [23:0] res_data;
    logic [2:0]  res_idx;
    logic        in_ready16, res_valid16, busy16, done16, overflow16;
    logic [15:0] res_data16;
    logic [2:0]  res_idx16;

    matvec_mac_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear),
        .signed_mode(signed_mode), .sat_en(sat_en), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .res_data(res_data),
        .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    matvec_mac_engine #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear),
        .signed_mode(signed_mode), .sat_en(sat_en), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready16), .res_data(res_data16),
        .res_idx(res_idx16), .res_valid(res_valid16), .res_ready(res_ready),
        .busy(busy16), .done(done16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a_kind;
        int          b_kind;
        bit          sgn;
        bit          sat;
        bit          clr;
        bit          gaps;
        bit          stall;
        logic [23:0] exp_r0;
        bit          exp_ovf24;
        bit          exp_ovf16;
    } job_t;

    typedef struct {
        int          idx;
        logic [23:0] d24;
        logic [15:0] d16;
    } exp_t;

    job_t   jobs[11];
    exp_t   sb[$];
    longint macc24[ROWS];
    longint macc16[ROWS];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] elem_a(input int kind, input int row);
        case (kind)
            0:       return 8'(row + 1);
            1:       return 8'hFF;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] elem_b(input int kind, input int col);
        case (kind)
            0:       return 8'(col + 1);
            1:       return 8'h02;
            2:       return 8'hFF;
            3:       return 8'h80;
            default: return 8'h7F;
        endcase
    endfunction

    // Integer reference: interpret stored bits, add, range-check, clamp or wrap.
    function automatic longint mstep(input longint raw, input longint p, input int w,
                                     input bit sgn, input bit sat);
        longint full, v, lo, hi, s;
        full = longint'(1) << w;
        v    = (sgn && raw >= full / 2) ? raw - full : raw;
        lo   = sgn ? -(full / 2) : 0;
        hi   = sgn ? full / 2 - 1 : full - 1;
        s    = v + p;
        if (sat && s < lo) s = lo;
        if (sat && s > hi) s = hi;
        return s & (full - 1);
    endfunction

    task automatic zero_model();
        for (int r = 0; r < ROWS; r++) begin
            macc24[r] = 0;
            macc16[r] = 0;
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        start = 1'b0;
        step();
        chk({name, "_rst_out24"}, {in_ready, res_valid, busy, done, overflow, res_data, res_idx}, '0);
        chk({name, "_rst_out16"}, {in_ready16, res_valid16, busy16, done16, overflow16, res_data16, res_idx16}, '0);
        rst = 1'b0;
        zero_model();
        sb.delete();
        step();
    endtask

    task automatic run_job(input job_t j, input int abort);
        logic [7:0]  el[$];
        logic [7:0]  a, b;
        longint      p;
        exp_t        x;
        logic [23:0] hold_d;
        logic [2:0]  hold_i;
        bit          ok, bt;
        int          e, t;

        if (j.clr) zero_model();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a = elem_a(j.a_kind, r);
                b = elem_b(j.b_kind, c);
                p = j.sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
                macc24[r] = mstep(macc24[r], p, 24, j.sgn, j.sat);
                macc16[r] = mstep(macc16[r], p, 16, j.sgn, j.sat);
            end
            x.idx = r;
            x.d24 = 24'(macc24[r]);
            x.d16 = 16'(macc16[r]);
            sb.push_back(x);
        end

        t = 0;
        while (busy && t < 300) begin step(); t++; end
        acc_clear   = j.clr;
        signed_mode = j.sgn;
        sat_en      = j.sat;
        start       = 1'b1;
        step();
        start       = 1'b0;
        acc_clear   = ~j.clr;
        signed_mode = ~j.sgn;
        sat_en      = ~j.sat;
        chk("busy_after_start", {busy, in_ready}, 2'b11);

        for (int c = 0; c < COLS; c++) el.push_back(elem_b(j.b_kind, c));
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) el.push_back(elem_a(j.a_kind, r));

        e = 0;
        t = 0;
        while (e < el.size() && t < 2000) begin
            in_valid = j.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = el[e];
            if (j.gaps && (t == 5 || t == 40)) start = 1'b1;
            bt = in_valid && in_ready;
            step();
            start = 1'b0;
            if (bt) e++;
            t++;
            if (abort == 1 && e == COLS + 5) begin
                do_reset("fill_a");
                return;
            end
        end
        in_valid = 1'b0;
        chk("load_complete", 64'(e), 64'(el.size()));

        for (int k = 0; k < ROWS; k++) begin
            res_ready = !j.stall;
            t = 0;
            while (!res_valid && t < 100) begin step(); t++; end
            chk("res_valid_seen", {res_valid, res_valid16}, 2'b11);
            if (j.stall) begin
                hold_d = res_data;
                hold_i = res_idx;
                ok = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    step();
                    if (!res_valid || res_data !== hold_d || res_idx !== hold_i) ok = 1'b0;
                end
                chk("stall_stable", 64'(ok), 64'd1);
                res_ready = 1'b1;
            end
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("res_idx", 64'(res_idx), 64'(x.idx));
                chk("res_data24", 64'(res_data), 64'(x.d24));
                chk("res_idx16", 64'(res_idx16), 64'(x.idx));
                chk("res_data16", 64'(res_data16), 64'(x.d16));
                if (k == 0) chk("res0_table", 64'(res_data), 64'(j.exp_r0));
            end else begin
                chk("scoreboard_empty", 64'(sb.size()), 64'd1);
            end
            step();
            if (abort == 2 && k == 1) begin
                do_reset("drain");
                return;
            end
        end
        chk("done_pulse", {done, done16, res_valid}, 3'b110);
        chk("overflow24", 64'(overflow), 64'(j.exp_ovf24));
        chk("overflow16", 64'(overflow16), 64'(j.exp_ovf16));
        step();
        chk("done_one_cycle", {done, busy, done16, busy16}, 4'b0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        job_t jf;
        //           a  b  sgn  sat  clr  gap  stl  r0         ovf24 ovf16
        jobs[0]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'd36,     1'b0, 1'b0};
        jobs[1]  = '{1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFF0, 1'b0, 1'b0};
        jobs[2]  = '{1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h07F008, 1'b0, 1'b1};
        jobs[3]  = '{1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h07F008, 1'b0, 1'b1};
        jobs[4]  = '{2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h020000, 1'b0, 1'b1};
        jobs[5]  = '{2, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFE0400, 1'b0, 1'b1};
        jobs[6]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'd36,     1'b0, 1'b0};
        jobs[7]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd72,     1'b0, 1'b0};
        jobs[8]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'd36,     1'b0, 1'b0};
        jobs[9]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'd36,     1'b0, 1'b0};
        jobs[10] = '{1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'd20,     1'b0, 1'b0};

        zero_model();
        rst = 1'b1;
        repeat (3) step();
        chk("reset_out24", {in_ready, res_valid, busy, done, overflow, res_data, res_idx}, '0);
        chk("reset_out16", {in_ready16, res_valid16, busy16, done16, overflow16, res_data16, res_idx16}, '0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) run_job(jobs[i], 0);

        jf = jobs[0];
        jf.clr = 1'b0;
        run_job(jobs[0], 1);
        run_job(jf, 0);
        run_job(jobs[0], 2);
        run_job(jf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
